dp_alu_stage: RTL and testbench
===============================

// Module: dp_alu_stage
// PURPOSE
//  Execute stage for ARM data-processing instructions. Consumes the barrel shifter's
//  shifter_operand/shift_carry_out together with Rn. Evaluates the condition code,
//  computes the 16 DP opcodes and owns the NZCV flag register. Registers the result
//  toward writeback behind a valid/ready handshake. flag_c feeds the shifter's carry_in.
// PARAMETERS
//  DW          32   datapath width (only 32 is supported)
//  RESET_NZCV  4'h0 flag register value after reset
// PORTS
//  clk            in   1   single clock, rising edge
//  rst_n          in   1   asynchronous active-low reset
//  in_valid       in   1   decoded DP instruction present
//  in_ready       out  1   stage can accept this cycle
//  cond           in   4   ARM condition field [31:28]
//  opcode         in   4   DP opcode [24:21]
//  s_bit          in   1   set-flags bit [20]
//  rd_in          in   4   destination register index
//  rn_val         in   DW  first operand (Rn value)
//  shifter_op     in   DW  shifter_operand from the barrel shifter
//  shifter_c      in   1   shift_carry_out from the barrel shifter
//  flush          in   1   synchronous kill of the held and incoming instruction
//  out_valid      out  1   result register holds an instruction
//  out_ready      in   1   writeback accepts the result
//  result         out  DW  ALU result
//  rd_out         out  4   destination index
//  rd_we          out  1   write Rd (0 for TST/TEQ/CMP/CMN or condition fail)
//  nzcv           out  4   current flags {N,Z,C,V}
//  flag_c         out  1   nzcv[1], to shifter carry_in
// BEHAVIOUR
//  Reset (async, rst_n=0):
//   out_valid=0, result=0, rd_out=0, rd_we=0, nzcv=RESET_NZCV. Any held instruction is lost.
//  Handshake:
//   in_ready = !out_valid | out_ready (combinational).
//   Accept = in_valid & in_ready. The output register loads on accept.
//   out_valid clears when out_ready is high and nothing new is accepted.
//   Latency is 1 cycle from accept to out_valid.
//   Outputs hold stable while out_valid & !out_ready.
//  Condition:
//   Evaluated against the nzcv register value at the accept edge.
//   EQ NE CS CC MI PL VS VC HI LS GE LT GT LE AL follow ARM semantics; NV (4'hF) is treated as never.
//   On fail: the instruction still passes as a bubble, out_valid=1, rd_we=0, result=0, and nzcv is unchanged.
//  Ops (a=rn_val, b=shifter_op):
//   AND a&b; EOR a^b; SUB a-b; RSB b-a; ADD a+b; ADC a+b+C; SBC a-b-!C; RSC b-a-!C;
//   TST a&b; TEQ a^b; CMP a-b; CMN a+b; ORR a|b; MOV b; BIC a&~b; MVN ~b.
//   All arithmetic uses a 33-bit adder: subtraction is x+~y+cin.
//   C is the adder bit 32, i.e. NOT borrow for subtracts.
//   V = signed overflow of operands to result.
//  Flag update:
//   Happens at the accept edge when the condition passes and (s_bit | opcode in 8..11).
//   TST/TEQ/CMP/CMN always update, regardless of s_bit.
//   N=result[31]; Z=(result==0).
//   Logical ops: C=shifter_c, V unchanged. Arithmetic ops: C and V from the adder.
//  Back-to-back:
//   Flags written at accept N are visible to the condition and ADC carry of the instruction accepted at N+1.
//   No stall or forwarding is required.
//  rd_we:
//   1 iff the condition passes and opcode not in 8..11.
//   Rd=15 gets no special handling (no CPSR/SPSR copy).
//  flush:
//   Sets out_valid=0 next cycle and blocks any accept that cycle.
//   Does not roll back nzcv already written.
//   flush has priority over in_valid and out_ready.
// TESTING
//  1 Reset mid-stream with out_valid=1 -> out_valid=0 and nzcv=0 immediately (async, before the next clk edge).
//  2 ADD: a=32'h7FFFFFFF, b=1, S=1, AL -> result=32'h80000000, nzcv=4'b1001, rd_we=1, one cycle later.
//  3 CMP: a=5, b=5 -> rd_we=0, nzcv=4'b0110; a following ADDNE is a bubble with rd_we=0;
//    a following ADDEQ a=1, b=2 gives result=3.
//  4 ADC back-to-back: SUBS 0-1 (C=0) followed by ADC a=10, b=0 -> result=10.
//    Then ADDS 32'hFFFFFFFF+1 (C=1) followed by ADC a=10, b=0 -> result=11.
//  5 MOVS b=0, shifter_c=1 with V preset to 1 -> nzcv=4'b0111.
//    ANDS without flag-setting opcode and S=0 -> nzcv unchanged.
//  6 Backpressure: out_ready=0 for 3 cycles with in_valid=1 -> in_ready=0, result held.
//    Releasing out_ready gives a single transfer per cycle thereafter.
//    flush during a stall -> out_valid=0 next cycle, nzcv retained.

Source files
------------

// File: rtl/dp_alu_stage.sv
// Execute stage for ARM data-processing instructions: condition check, 16-op ALU,
// NZCV flag register and a one-deep registered result behind a valid/ready handshake.
module dp_alu_stage #(
    parameter int         DW         = 32,
    parameter logic [3:0] RESET_NZCV = 4'h0
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          in_valid,
    output logic          in_ready,
    input  logic [3:0]    cond,
    input  logic [3:0]    opcode,
    input  logic          s_bit,
    input  logic [3:0]    rd_in,
    input  logic [DW-1:0] rn_val,
    input  logic [DW-1:0] shifter_op,
    input  logic          shifter_c,
    input  logic          flush,
    output logic          out_valid,
    input  logic          out_ready,
    output logic [DW-1:0] result,
    output logic [3:0]    rd_out,
    output logic          rd_we,
    output logic [3:0]    nzcv,
    output logic          flag_c
);

    typedef enum logic [3:0] {
        OP_AND = 4'h0, OP_EOR = 4'h1, OP_SUB = 4'h2, OP_RSB = 4'h3,
        OP_ADD = 4'h4, OP_ADC = 4'h5, OP_SBC = 4'h6, OP_RSC = 4'h7,
        OP_TST = 4'h8, OP_TEQ = 4'h9, OP_CMP = 4'hA, OP_CMN = 4'hB,
        OP_ORR = 4'hC, OP_MOV = 4'hD, OP_BIC = 4'hE, OP_MVN = 4'hF
    } dp_op_e;

    logic          n_f, z_f, c_f, v_f;
    logic          cond_pass;
    logic          is_test;
    logic          accept;
    logic          is_arith;
    logic [DW-1:0] add_x, add_y, logic_res, alu_res;
    logic          add_cin;
    logic [DW:0]   add_sum;
    logic          add_v;
    logic [3:0]    new_nzcv;

    assign {n_f, z_f, c_f, v_f} = nzcv;
    assign flag_c   = nzcv[1];
    assign in_ready = !out_valid || out_ready;
    assign accept   = in_valid && in_ready && !flush;
    assign is_test  = (opcode[3:2] == 2'b10);

    always_comb begin
        cond_pass = 1'b0;
        case (cond)
            4'h0: cond_pass = z_f;
            4'h1: cond_pass = !z_f;
            4'h2: cond_pass = c_f;
            4'h3: cond_pass = !c_f;
            4'h4: cond_pass = n_f;
            4'h5: cond_pass = !n_f;
            4'h6: cond_pass = v_f;
            4'h7: cond_pass = !v_f;
            4'h8: cond_pass = c_f && !z_f;
            4'h9: cond_pass = !c_f || z_f;
            4'hA: cond_pass = (n_f == v_f);
            4'hB: cond_pass = (n_f != v_f);
            4'hC: cond_pass = !z_f && (n_f == v_f);
            4'hD: cond_pass = z_f || (n_f != v_f);
            4'hE: cond_pass = 1'b1;
            default: cond_pass = 1'b0;
        endcase
    end

    // Every arithmetic op maps onto one adder; subtracts invert an operand and use cin.
    always_comb begin
        add_x     = rn_val;
        add_y     = shifter_op;
        add_cin   = 1'b0;
        is_arith  = 1'b0;
        logic_res = '0;
        case (dp_op_e'(opcode))
            OP_AND, OP_TST: logic_res = rn_val & shifter_op;
            OP_EOR, OP_TEQ: logic_res = rn_val ^ shifter_op;
            OP_ORR:         logic_res = rn_val | shifter_op;
            OP_MOV:         logic_res = shifter_op;
            OP_BIC:         logic_res = rn_val & ~shifter_op;
            OP_MVN:         logic_res = ~shifter_op;
            OP_SUB, OP_CMP: begin
                is_arith = 1'b1;
                add_y    = ~shifter_op;
                add_cin  = 1'b1;
            end
            OP_RSB: begin
                is_arith = 1'b1;
                add_x    = shifter_op;
                add_y    = ~rn_val;
                add_cin  = 1'b1;
            end
            OP_ADD, OP_CMN: is_arith = 1'b1;
            OP_ADC: begin
                is_arith = 1'b1;
                add_cin  = c_f;
            end
            OP_SBC: begin
                is_arith = 1'b1;
                add_y    = ~shifter_op;
                add_cin  = c_f;
            end
            OP_RSC: begin
                is_arith = 1'b1;
                add_x    = shifter_op;
                add_y    = ~rn_val;
                add_cin  = c_f;
            end
            default: logic_res = '0;
        endcase
    end

    assign add_sum  = {1'b0, add_x} + {1'b0, add_y} + {{DW{1'b0}}, add_cin};
    assign add_v    = (add_x[DW-1] == add_y[DW-1]) && (add_sum[DW-1] != add_x[DW-1]);
    assign alu_res  = is_arith ? add_sum[DW-1:0] : logic_res;
    assign new_nzcv = {alu_res[DW-1], (alu_res == '0),
                       is_arith ? add_sum[DW] : shifter_c,
                       is_arith ? add_v : v_f};

    // Failed conditions still occupy the output slot as a bubble with no side effects.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            out_valid <= 1'b0;
            result    <= '0;
            rd_out    <= 4'h0;
            rd_we     <= 1'b0;
            nzcv      <= RESET_NZCV;
        end else if (flush) begin
            out_valid <= 1'b0;
        end else if (accept) begin
            out_valid <= 1'b1;
            result    <= cond_pass ? alu_res : '0;
            rd_out    <= rd_in;
            rd_we     <= cond_pass && !is_test;
            if (cond_pass && (s_bit || is_test))
                nzcv <= new_nzcv;
        end else if (out_ready) begin
            out_valid <= 1'b0;
        end
    end

endmodule

// File: tb/tb_dp_alu_stage.sv
// Randomized and directed bench for dp_alu_stage, checked every cycle against an
// arithmetic reference model of the ARM data-processing rules.
module tb_dp_alu_stage;

    logic        clk = 1'b0;
    logic        rst_n = 1'b1;
    logic        in_valid = 1'b0;
    logic        in_ready;
    logic [3:0]  cond = 4'hE;
    logic [3:0]  opcode = 4'h0;
    logic        s_bit = 1'b0;
    logic [3:0]  rd_in = 4'h0;
    logic [31:0] rn_val = 32'h0;
    logic [31:0] shifter_op = 32'h0;
    logic        shifter_c = 1'b0;
    logic        flush = 1'b0;
    logic        out_valid;
    logic        out_ready = 1'b1;
    logic [31:0] result;
    logic [3:0]  rd_out;
    logic        rd_we;
    logic [3:0]  nzcv;
    logic        flag_c;

    int          n_cmp = 0;
    int          n_fail = 0;
    bit          checking = 1'b0;

    bit          m_valid = 1'b0;
    logic [31:0] m_result = 32'h0;
    logic [3:0]  m_rd = 4'h0;
    bit          m_we = 1'b0;
    logic [3:0]  m_nzcv = 4'h0;

    dp_alu_stage #(.DW(32), .RESET_NZCV(4'h0)) dut (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
        .cond(cond), .opcode(opcode), .s_bit(s_bit), .rd_in(rd_in),
        .rn_val(rn_val), .shifter_op(shifter_op), .shifter_c(shifter_c),
        .flush(flush), .out_valid(out_valid), .out_ready(out_ready),
        .result(result), .rd_out(rd_out), .rd_we(rd_we), .nzcv(nzcv), .flag_c(flag_c)
    );

    always #5 clk = ~clk;

    task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_fail++;
            $display("[TB] FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic bit model_cond(input logic [3:0] c, input logic [3:0] f);
        bit n, z, cy, v;
        {n, z, cy, v} = f;
        case (c)
            4'h0: return z;
            4'h1: return !z;
            4'h2: return cy;
            4'h3: return !cy;
            4'h4: return n;
            4'h5: return !n;
            4'h6: return v;
            4'h7: return !v;
            4'h8: return cy && !z;
            4'h9: return !cy || z;
            4'hA: return n == v;
            4'hB: return n != v;
            4'hC: return !z && n == v;
            4'hD: return z || n != v;
            4'hE: return 1'b1;
            default: return 1'b0;
        endcase
    endfunction

    // Reference: results from wide unsigned/signed arithmetic, not from an adder model.
    function automatic void model_exec(input logic [3:0] op, input logic [31:0] a, input logic [31:0] b,
                                       input bit cin, input bit sc, input logic [3:0] f_in,
                                       output logic [31:0] r, output logic [3:0] f_out);
        longint unsigned ux, uy, extra;
        longint sx, sy, s;
        bit arith, sub, cy, vv;
        logic [31:0] x, y;
        arith = 1'b1; sub = 1'b0; extra = 0; x = a; y = b; r = 32'h0;
        case (op)
            4'h0, 4'h8: begin r = a & b;  arith = 1'b0; end
            4'h1, 4'h9: begin r = a ^ b;  arith = 1'b0; end
            4'hC:       begin r = a | b;  arith = 1'b0; end
            4'hD:       begin r = b;      arith = 1'b0; end
            4'hE:       begin r = a & ~b; arith = 1'b0; end
            4'hF:       begin r = ~b;     arith = 1'b0; end
            4'h2, 4'hA: sub = 1'b1;
            4'h3:       begin sub = 1'b1; x = b; y = a; end
            4'h5:       extra = cin;
            4'h6:       begin sub = 1'b1; extra = !cin; end
            4'h7:       begin sub = 1'b1; x = b; y = a; extra = !cin; end
            default:    extra = 0;
        endcase
        ux = x; uy = y; sx = $signed(x); sy = $signed(y);
        if (arith) begin
            if (sub) begin
                cy = ux >= uy + extra;
                s  = sx - sy - longint'(extra);
                r  = 32'(ux - uy - extra);
            end else begin
                cy = (ux + uy + extra) > 64'hFFFF_FFFF;
                s  = sx + sy + longint'(extra);
                r  = 32'(ux + uy + extra);
            end
            vv = (s > 64'sd2147483647) || (s < -64'sd2147483648);
        end else begin
            cy = sc;
            vv = f_in[0];
        end
        f_out = {r[31], r == 32'h0, cy, vv};
    endfunction

    task automatic applyStimulus(input bit iv, input logic [3:0] cnd, input logic [3:0] op, input bit s,
                                 input logic [3:0] rd, input logic [31:0] a, input logic [31:0] b,
                                 input bit sc, input bit fl, input bit ordy);
        bit          n_valid, n_we, acc, pass;
        logic [31:0] n_result, r;
        logic [3:0]  n_rd, n_nzcv, f;
        in_valid = iv; cond = cnd; opcode = op; s_bit = s; rd_in = rd;
        rn_val = a; shifter_op = b; shifter_c = sc; flush = fl; out_ready = ordy;
        n_valid = m_valid; n_result = m_result; n_rd = m_rd; n_we = m_we; n_nzcv = m_nzcv;
        acc = iv && (!m_valid || ordy) && !fl;
        if (fl) begin
            n_valid = 1'b0;
        end else if (acc) begin
            pass = model_cond(cnd, m_nzcv);
            model_exec(op, a, b, m_nzcv[1], sc, m_nzcv, r, f);
            n_valid  = 1'b1;
            n_result = pass ? r : 32'h0;
            n_rd     = rd;
            n_we     = pass && !(op >= 4'h8 && op <= 4'hB);
            if (pass && (s || (op >= 4'h8 && op <= 4'hB)))
                n_nzcv = f;
        end else if (ordy) begin
            n_valid = 1'b0;
        end
        @(posedge clk);
        m_valid = n_valid; m_result = n_result; m_rd = n_rd; m_we = n_we; m_nzcv = n_nzcv;
        #2;
    endtask

    always @(negedge clk) begin
        if (checking) begin
            checkOutput("out_valid", 32'(out_valid), 32'(m_valid));
            checkOutput("nzcv", 32'(nzcv), 32'(m_nzcv));
            checkOutput("flag_c", 32'(flag_c), 32'(m_nzcv[1]));
            checkOutput("in_ready", 32'(in_ready), 32'(!m_valid || out_ready));
            if (m_valid) begin
                checkOutput("result", result, m_result);
                checkOutput("rd_out", 32'(rd_out), 32'(m_rd));
                checkOutput("rd_we", 32'(rd_we), 32'(m_we));
            end
        end
    end

    function automatic logic [31:0] pick_operand();
        case ($urandom_range(7))
            0: return 32'h0000_0000;
            1: return 32'hFFFF_FFFF;
            2: return 32'h8000_0000;
            3: return 32'h7FFF_FFFF;
            4: return 32'($urandom_range(3));
            default: return $urandom;
        endcase
    endfunction

    initial begin
        #1 rst_n = 1'b0;
        #11 rst_n = 1'b1;
        checking = 1'b1;
        @(posedge clk); #2;
        checkOutput("reset_out_valid", 32'(out_valid), 32'h0);
        checkOutput("reset_nzcv", 32'(nzcv), 32'h0);
        checkOutput("reset_result", result, 32'h0);
        checkOutput("reset_rd_we", 32'(rd_we), 32'h0);

        // ADDS overflow into the sign bit
        applyStimulus(1, 4'hE, 4'h4, 1, 4'd3, 32'h7FFF_FFFF, 32'h1, 0, 0, 1);
        checkOutput("adds_result", result, 32'h8000_0000);
        checkOutput("adds_nzcv", 32'(nzcv), 32'h9);
        checkOutput("adds_rd_we", 32'(rd_we), 32'h1);

        // CMP equal, then NE bubble, then EQ executes
        applyStimulus(1, 4'hE, 4'hA, 0, 4'd1, 32'd5, 32'd5, 0, 0, 1);
        checkOutput("cmp_rd_we", 32'(rd_we), 32'h0);
        checkOutput("cmp_nzcv", 32'(nzcv), 32'h6);
        applyStimulus(1, 4'h1, 4'h4, 0, 4'd2, 32'd1, 32'd2, 0, 0, 1);
        checkOutput("addne_valid", 32'(out_valid), 32'h1);
        checkOutput("addne_rd_we", 32'(rd_we), 32'h0);
        checkOutput("addne_result", result, 32'h0);
        applyStimulus(1, 4'h0, 4'h4, 0, 4'd2, 32'd1, 32'd2, 0, 0, 1);
        checkOutput("addeq_result", result, 32'd3);
        checkOutput("addeq_rd_we", 32'(rd_we), 32'h1);

        // ADC picks up the carry written by the previous instruction
        applyStimulus(1, 4'hE, 4'h2, 1, 4'd4, 32'd0, 32'd1, 0, 0, 1);
        checkOutput("subs_nzcv", 32'(nzcv), 32'h8);
        applyStimulus(1, 4'hE, 4'h5, 0, 4'd4, 32'd10, 32'd0, 0, 0, 1);
        checkOutput("adc_c0", result, 32'd10);
        applyStimulus(1, 4'hE, 4'h4, 1, 4'd4, 32'hFFFF_FFFF, 32'd1, 0, 0, 1);
        checkOutput("adds_wrap_nzcv", 32'(nzcv), 32'h6);
        applyStimulus(1, 4'hE, 4'h5, 0, 4'd4, 32'd10, 32'd0, 0, 0, 1);
        checkOutput("adc_c1", result, 32'd11);

        // Logical flag rules: V preserved, C from shifter, S=0 leaves flags alone
        applyStimulus(1, 4'hE, 4'h4, 1, 4'd5, 32'h7FFF_FFFF, 32'h1, 0, 0, 1);
        applyStimulus(1, 4'hE, 4'hD, 1, 4'd5, 32'h0, 32'h0, 1, 0, 1);
        checkOutput("movs_nzcv", 32'(nzcv), 32'h7);
        applyStimulus(1, 4'hE, 4'h0, 0, 4'd5, 32'h0, 32'h0, 0, 0, 1);
        checkOutput("and_nos_nzcv", 32'(nzcv), 32'h7);

        // Backpressure, release, then flush during a stall
        applyStimulus(1, 4'hE, 4'hD, 0, 4'd6, 32'h0, 32'h1234, 0, 0, 1);
        for (int i = 0; i < 3; i++) begin
            applyStimulus(1, 4'hE, 4'hD, 0, 4'd7, 32'h0, 32'hDEAD, 0, 0, 0);
            checkOutput("stall_in_ready", 32'(in_ready), 32'h0);
            checkOutput("stall_result", result, 32'h1234);
        end
        for (int i = 0; i < 4; i++) begin
            applyStimulus(1, 4'hE, 4'hD, 0, 4'd8, 32'h0, 32'(100 + i), 0, 0, 1);
            checkOutput("release_result", result, 32'(100 + i));
        end
        applyStimulus(1, 4'hE, 4'hD, 0, 4'd9, 32'h0, 32'h55, 0, 0, 0);
        checkOutput("restall_result", result, 32'd103);
        applyStimulus(1, 4'hE, 4'hA, 1, 4'd9, 32'h0, 32'h0, 0, 1, 0);
        checkOutput("flush_valid", 32'(out_valid), 32'h0);
        checkOutput("flush_nzcv", 32'(nzcv), 32'h7);

        // Asynchronous reset while a result is held
        applyStimulus(1, 4'hE, 4'h4, 1, 4'd3, 32'h7FFF_FFFF, 32'h1, 0, 0, 0);
        checkOutput("pre_reset_valid", 32'(out_valid), 32'h1);
        in_valid = 1'b0;
        rst_n = 1'b0;
        m_valid = 1'b0; m_nzcv = 4'h0;
        #1;
        checkOutput("async_reset_valid", 32'(out_valid), 32'h0);
        checkOutput("async_reset_nzcv", 32'(nzcv), 32'h0);
        @(posedge clk); #2;
        rst_n = 1'b1;

        for (int i = 0; i < 3000; i++) begin
            applyStimulus(($urandom_range(9) < 7), ($urandom_range(1) == 1) ? 4'hE : 4'($urandom_range(15)),
                          4'($urandom_range(15)), 1'($urandom_range(1)), 4'($urandom_range(15)),
                          pick_operand(), pick_operand(), 1'($urandom_range(1)),
                          ($urandom_range(19) == 0), ($urandom_range(9) < 7));
        end

        @(negedge clk); #1;
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
